// File: rtl/raw_pattern_gen.sv
//==============================================================================
// raw_pattern_gen
// Raw Bayer test-pattern source: frame timing (vsync/hsync/den) plus a
// selectable pattern mosaiced to one 8-bit raw sample per pixel.
// Startup: vsync rises V_BLANK*(H_ACTIVE+H_BLANK)+1 cycles after the cycle in
// which enable is first seen high in IDLE.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module raw_pattern_gen #(
    parameter int H_ACTIVE = 512,
    parameter int V_ACTIVE = 512,
    parameter int H_BLANK  = 64,
    parameter int V_BLANK  = 4,
    parameter int BAYER    = 0,
    parameter int BAR_W    = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [7:0]  gray,
    output logic        out_vsync,
    output logic        out_hsync,
    output logic        out_den,
    output logic [7:0]  out_raw,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int LINE   = H_ACTIVE + H_BLANK;
    localparam int VB_CYC = V_BLANK * LINE;
    localparam int XW     = ($clog2(H_ACTIVE) > 10) ? $clog2(H_ACTIVE) : 10;
    localparam int YW     = ($clog2(V_ACTIVE) > 10) ? $clog2(V_ACTIVE) : 10;
    localparam int CW0    = $clog2(VB_CYC + 1);
    localparam int CW     = (CW0 > XW) ? CW0 : XW;
    localparam int BAR_SH = $clog2(BAR_W);

    typedef enum logic [1:0] {IDLE, VBLANK, HBLANK, ACTIVE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;      // position within the current state
    logic [YW-1:0]  y_q, y_d;
    logic [1:0]     mode_q, mode_d;    // frame-latched pattern selection
    logic [7:0]     gray_q, gray_d;
    logic [15:0]    fcnt_q, fcnt_d;
    logic           done_d;
    logic           vsync_q, hsync_q, done_q;
    logic [7:0]     raw_q, raw_d;

    logic [XW-1:0]  x_n;
    logic [XW-1:0]  bar_full;
    logic [2:0]     bar;
    logic [2:0]     rgb;
    logic [1:0]     site;
    logic           comp;

    // Next-state sequencing of frame/line timing and pixel value for the next cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        mode_d   = mode_q;
        gray_d   = gray_q;
        fcnt_d   = fcnt_q;
        done_d   = 1'b0;
        raw_d    = 8'h00;
        x_n      = '0;
        bar_full = '0;
        bar      = 3'd0;
        rgb      = 3'b000;
        site     = 2'b00;
        comp     = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = VBLANK;
                    cnt_d   = '0;
                end
            end
            VBLANK: begin
                if (cnt_q == CW'(VB_CYC - 1)) begin
                    cnt_d = '0;
                    if (enable) begin
                        state_d = HBLANK;
                        y_d     = '0;
                        mode_d  = mode;
                        gray_d  = gray;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HBLANK: begin
                if (cnt_q == CW'(H_BLANK - 1)) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACTIVE: begin
                if (cnt_q == CW'(H_ACTIVE - 1)) begin
                    cnt_d = '0;
                    if (y_q == YW'(V_ACTIVE - 1)) begin
                        state_d = VBLANK;
                        done_d  = 1'b1;
                        fcnt_d  = fcnt_q + 16'd1;
                    end else begin
                        state_d = HBLANK;
                        y_d     = y_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pixel generation uses next-cycle coordinates so out_raw lands with den
        x_n      = cnt_d[XW-1:0];
        bar_full = x_n >> BAR_SH;
        bar      = (bar_full > XW'(7)) ? 3'd7 : bar_full[2:0];
        case (bar)
            3'd0:    rgb = 3'b111;   // white
            3'd1:    rgb = 3'b110;   // yellow
            3'd2:    rgb = 3'b011;   // cyan
            3'd3:    rgb = 3'b010;   // green
            3'd4:    rgb = 3'b101;   // magenta
            3'd5:    rgb = 3'b100;   // red
            3'd6:    rgb = 3'b001;   // blue
            default: rgb = 3'b000;   // black
        endcase
        // Every CFA phase is RGGB with x and/or y parity flipped
        site = {y_d[0], x_n[0]} ^ 2'(BAYER);
        case (site)
            2'b00:   comp = rgb[2];
            2'b11:   comp = rgb[0];
            default: comp = rgb[1];
        endcase

        if (state_d == ACTIVE) begin
            case (mode_d)
                2'd0:    raw_d = comp ? 8'hFF : 8'h00;
                2'd1:    raw_d = gray_d;
                2'd2:    raw_d = x_n[7:0] + y_d[7:0];
                default: raw_d = (x_n[3] ^ y_d[3]) ? 8'hFF : 8'h00;
            endcase
        end
    end

    // State, counters and registered outputs with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            mode_q  <= 2'd0;
            gray_q  <= 8'h00;
            fcnt_q  <= 16'd0;
            vsync_q <= 1'b0;
            hsync_q <= 1'b0;
            done_q  <= 1'b0;
            raw_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            gray_q  <= gray_d;
            fcnt_q  <= fcnt_d;
            vsync_q <= (state_d == HBLANK) || (state_d == ACTIVE);
            hsync_q <= (state_d == ACTIVE);
            done_q  <= done_d;
            raw_q   <= raw_d;
        end
    end

    assign out_vsync  = vsync_q;
    assign out_hsync  = hsync_q;
    assign out_den    = hsync_q;
    assign out_raw    = raw_q;
    assign frame_done = done_q;
    assign frame_cnt  = fcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_raw_pattern_gen.sv
//==============================================================================
// tb_raw_pattern_gen
// Self-checking bench for raw_pattern_gen on a reduced frame geometry, with
// three instances sharing stimulus to cover BAYER phases 0, 1 and 3.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_raw_pattern_gen;

    localparam int H_A   = 320;
    localparam int V_A   = 12;
    localparam int H_B   = 8;
    localparam int V_B   = 2;
    localparam int BW    = 32;
    localparam int LINE  = H_A + H_B;
    localparam int N     = V_B * LINE;
    localparam int FRAME = (V_A + V_B) * LINE;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  mode;
    logic [7:0]  gray;

    logic        out_vsync, out_hsync, out_den, frame_done;
    logic [7:0]  out_raw;
    logic [15:0] frame_cnt;
    logic        b1_vs, b1_hs, b1_den, b1_done;
    logic [7:0]  b1_raw;
    logic [15:0] b1_cnt;
    logic        b3_vs, b3_hs, b3_den, b3_done;
    logic [7:0]  b3_raw;
    logic [15:0] b3_cnt;

    raw_pattern_gen #(.H_ACTIVE(H_A), .V_ACTIVE(V_A), .H_BLANK(H_B), .V_BLANK(V_B),
                      .BAYER(0), .BAR_W(BW)) u_b0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .gray(gray),
        .out_vsync(out_vsync), .out_hsync(out_hsync), .out_den(out_den),
        .out_raw(out_raw), .frame_done(frame_done), .frame_cnt(frame_cnt));

    raw_pattern_gen #(.H_ACTIVE(H_A), .V_ACTIVE(V_A), .H_BLANK(H_B), .V_BLANK(V_B),
                      .BAYER(1), .BAR_W(BW)) u_b1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .gray(gray),
        .out_vsync(b1_vs), .out_hsync(b1_hs), .out_den(b1_den),
        .out_raw(b1_raw), .frame_done(b1_done), .frame_cnt(b1_cnt));

    raw_pattern_gen #(.H_ACTIVE(H_A), .V_ACTIVE(V_A), .H_BLANK(H_B), .V_BLANK(V_B),
                      .BAYER(3), .BAR_W(BW)) u_b3 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .gray(gray),
        .out_vsync(b3_vs), .out_hsync(b3_hs), .out_den(b3_den),
        .out_raw(b3_raw), .frame_done(b3_done), .frame_cnt(b3_cnt));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Frame capture results
    logic [7:0] p0 [V_A][H_A];
    logic [7:0] p1 [V_A][H_A];
    logic [7:0] p3 [V_A][H_A];
    int lines, badlen, first_den, done_cnt, badzero, badsync, rise_c;
    logic done_at_fall, timed_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Steps negedges until vsync is high; d is cycles since reference k, -1 on timeout
    task automatic wait_rise(input int k, input int limit, output int d);
        d = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (out_vsync) begin
                d = cyc - k;
                break;
            end
        end
    endtask

    // Entered on the sample where vsync is first high; runs to the vsync-fall sample
    task automatic cap_frame(input int chg_line, input logic [1:0] chg_mode, input int drop_line);
        int x, y;
        logic pd;
        x = 0; y = 0; pd = 1'b0;
        lines = 0; badlen = 0; first_den = -1; done_cnt = 0;
        badzero = 0; badsync = 0; rise_c = cyc; done_at_fall = 1'b0; timed_out = 1'b1;
        for (int r = 0; r < V_A; r++)
            for (int c = 0; c < H_A; c++) begin
                p0[r][c] = 8'h00; p1[r][c] = 8'h00; p3[r][c] = 8'h00;
            end
        for (int i = 0; i < FRAME + 10; i++) begin
            if (out_den) begin
                if (first_den < 0) first_den = cyc - rise_c;
                if (y < V_A && x < H_A) begin
                    p0[y][x] = out_raw; p1[y][x] = b1_raw; p3[y][x] = b3_raw;
                end
                x++;
            end else begin
                if (out_raw != 8'h00 || b1_raw != 8'h00 || b3_raw != 8'h00) badzero++;
                if (pd) begin
                    if (x != H_A) badlen++;
                    lines++; y++; x = 0;
                end
            end
            if (out_den != out_hsync || b1_den != out_den || b3_den != out_den ||
                b1_hs != out_hsync || b3_hs != out_hsync ||
                b1_vs != out_vsync || b3_vs != out_vsync ||
                b1_done != frame_done || b3_done != frame_done ||
                b1_cnt != frame_cnt || b3_cnt != frame_cnt) badsync++;
            if (frame_done) done_cnt++;
            if (y == chg_line) mode = chg_mode;
            if (y == drop_line) enable = 1'b0;
            pd = out_den;
            if (!out_vsync) begin
                done_at_fall = frame_done;
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [15:0] exp_cnt);
        chk({tag, "_timeout"}, {31'd0, timed_out}, 32'd0);
        chk({tag, "_lines"}, lines, V_A);
        chk({tag, "_badlen"}, badlen, 0);
        chk({tag, "_first_den"}, first_den, H_B);
        chk({tag, "_done_at_fall"}, {31'd0, done_at_fall}, 32'd1);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_raw0_blank"}, badzero, 0);
        chk({tag, "_sync"}, badsync, 0);
        chk({tag, "_frame_cnt"}, {16'd0, frame_cnt}, {16'd0, exp_cnt});
    endtask

    initial begin
        int k, d, bad, vs_seen;
        reset_n = 1'b0; enable = 1'b0; mode = 2'd0; gray = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_outs", {4'd0, out_vsync, out_hsync, out_den, frame_done, out_raw, frame_cnt}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_vsync", {31'd0, out_vsync}, 32'd0);

        // Frame 0: colour bars
        k = cyc; enable = 1'b1;
        wait_rise(k, N + 20, d);
        chk("startup_delay", d, N + 1);
        cap_frame(-1, 2'd0, -1);
        chk_frame("f0", 16'd1);
        chk("bar_y0_x0", p0[0][0], 8'hFF);
        chk("bar_y0_x1", p0[0][1], 8'hFF);
        chk("bar_red_x160", p0[0][160], 8'hFF);
        chk("bar_red_x161", p0[0][161], 8'h00);
        chk("bar_y1_x0_G", p0[1][0], 8'hFF);
        chk("bar_y1_x1_B", p0[1][1], 8'hFF);
        chk("bar_green_R", p0[0][96], 8'h00);
        chk("bar_green_G", p0[0][97], 8'hFF);
        chk("bar_clamp_x300", p0[0][300], 8'h00);
        chk("b1_red_x160", p1[0][160], 8'h00);
        chk("b1_red_x161", p1[0][161], 8'hFF);
        chk("b3_red_x160", p3[0][160], 8'h00);

        // Frame 1: flat gray; mode switched mid-frame must not take effect
        mode = 2'd1; gray = 8'h5A;
        wait_rise(rise_c, FRAME + 20, d);
        chk("period_f0_f1", d, FRAME);
        cap_frame(5, 2'd2, -1);
        chk_frame("f1", 16'd2);
        bad = 0;
        for (int r = 0; r < V_A; r++)
            for (int c = 0; c < H_A; c++)
                if (p0[r][c] != 8'h5A || p3[r][c] != 8'h5A) bad++;
        chk("flat_all_5A", bad, 0);

        // Frame 2: ramp
        wait_rise(rise_c, FRAME + 20, d);
        chk("period_f1_f2", d, FRAME);
        cap_frame(5, 2'd3, -1);
        chk_frame("f2", 16'd3);
        chk("ramp_300_10", p0[10][300], 8'h36);
        chk("ramp_255_1", p0[1][255], 8'h00);
        chk("ramp_5_3", p0[3][5], 8'h08);
        chk("ramp_b3_300_10", p3[10][300], 8'h36);

        // Frame 3: checker; enable dropped mid-frame
        wait_rise(rise_c, FRAME + 20, d);
        chk("period_f2_f3", d, FRAME);
        cap_frame(-1, 2'd0, 5);
        chk_frame("f3", 16'd4);
        chk("chk_b1_7_0", p1[0][7], 8'h00);
        chk("chk_b1_8_0", p1[0][8], 8'hFF);
        chk("chk_b1_8_8", p1[8][8], 8'h00);
        chk("chk_b1_0_8", p1[8][0], 8'hFF);

        repeat (N + 4) @(negedge clk);
        chk("idle_outs", {4'd0, out_vsync, out_hsync, out_den, frame_done, out_raw, frame_cnt}, 32'h4);
        vs_seen = 0;
        for (int i = 0; i < 2 * LINE; i++) begin
            @(negedge clk);
            if (out_vsync || frame_done || out_den) vs_seen++;
        end
        chk("idle_stays", vs_seen, 0);

        // Restart, then reset in the middle of an active line
        k = cyc; enable = 1'b1;
        wait_rise(k, N + 20, d);
        chk("restart_delay", d, N + 1);
        repeat (20) @(negedge clk);
        chk("midact_den", {31'd0, out_den}, 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("async_reset", {4'd0, out_vsync, out_hsync, out_den, frame_done, out_raw, frame_cnt}, 32'd0);
        repeat (3) @(negedge clk);
        k = cyc; reset_n = 1'b1;
        wait_rise(k, N + 20, d);
        chk("post_reset_delay", d, N + 1);
        cap_frame(-1, 2'd3, -1);
        chk_frame("f4", 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
